scan_sel_gen: RTL and testbench

Upstream driver for the 2-to-4 enable decoder (decode). It sequences the decoder's select A[1:0] and enable E through the enabled output lines, holding each line for a programmable dwell time. It supports one-shot sweeps and continuous scanning, a line mask and a stop abort. Typical use is strobing multiplexed display digits or row drivers.

---
 rtl/scan_sel_pkg.sv | 13 +
 rtl/scan_next_idx.sv | 29 ++
 rtl/scan_sel_gen.sv | 143 ++++++++++++++
 tb/tb_scan_sel_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/scan_sel_pkg.sv
// Shared types and sizes for the scan select generator and its next-line finder.
package scan_sel_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned LINES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_e;

endpackage

// File: rtl/scan_next_idx.sv
// Combinational finder: next set mask bit above the current index, wrapping to
// the lowest set bit (o_wrap=1 when no higher bit exists).
module scan_next_idx
    import scan_sel_pkg::*;
(
    input  logic [SEL_W-1:0] i_idx,
    input  logic [LINES-1:0] i_mask,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_wrap
);

    always_comb begin
        o_idx  = '0;
        o_wrap = 1'b1;
        // Descending scans: the last hit is the lowest qualifying bit.
        for (int i = LINES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = SEL_W'(i);
            end
        end
        for (int i = LINES - 1; i >= 0; i--) begin
            if (i_mask[i] && (i > int'(i_idx))) begin
                o_idx  = SEL_W'(i);
                o_wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/scan_sel_gen.sv
// Sequences decoder select A and enable E across the masked lines with a fixed
// dwell; SCAN_SEL_BLANK_EN inserts BLANK_CYC dead cycles between lines.
module scan_sel_gen
    import scan_sel_pkg::*;
#(
    parameter int unsigned DWELL = 4
`ifdef SCAN_SEL_BLANK_EN
    ,
    parameter int unsigned BLANK_CYC = 1
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [LINES-1:0] mask,
    output logic [SEL_W-1:0] A,
    output logic             E,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_e             r_state;
    logic [7:0]         r_dwell;
    logic [LINES-1:0]   r_mask;
    logic               r_oneshot;
    logic [SEL_W-1:0]   r_a;
    logic               r_e;
    logic               r_busy;
    logic               r_done;

`ifdef SCAN_SEL_BLANK_EN
    localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYC - 1);
    logic [3:0]         r_blank;
    logic [SEL_W-1:0]   r_next;
`endif

    logic [SEL_W-1:0]   w_cur_idx;
    logic [LINES-1:0]   w_cur_mask;
    logic [SEL_W-1:0]   w_next_idx;
    logic               w_wrap;

    // In IDLE, searching above the top index yields the lowest set bit of the live mask.
    assign w_cur_idx  = (r_state == ST_IDLE) ? '1 : r_a;
    assign w_cur_mask = (r_state == ST_IDLE) ? mask : r_mask;

    scan_next_idx u_next (
        .i_idx  (w_cur_idx),
        .i_mask (w_cur_mask),
        .o_idx  (w_next_idx),
        .o_wrap (w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_dwell   <= '0;
            r_mask    <= '0;
            r_oneshot <= 1'b0;
            r_a       <= '0;
            r_e       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SCAN_SEL_BLANK_EN
            r_blank   <= '0;
            r_next    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && (mask != '0)) begin
                        r_mask    <= mask;
                        r_oneshot <= oneshot;
                        r_a       <= w_next_idx;
                        r_e       <= 1'b1;
                        r_busy    <= 1'b1;
                        r_dwell   <= '0;
                        r_state   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_a     <= '0;
                        r_e     <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        if (w_wrap && r_oneshot) begin
                            r_state <= ST_IDLE;
                            r_a     <= '0;
                            r_e     <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
`ifdef SCAN_SEL_BLANK_EN
                            r_state <= ST_BLANK;
                            r_e     <= 1'b0;
                            r_next  <= w_next_idx;
                            r_blank <= '0;
`else
                            r_a     <= w_next_idx;
`endif
                        end
                    end else begin
                        r_dwell <= r_dwell + 8'd1;
                    end
                end
`ifdef SCAN_SEL_BLANK_EN
                ST_BLANK: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_a     <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_blank == BLANK_LAST) begin
                        r_state <= ST_ACTIVE;
                        r_a     <= r_next;
                        r_e     <= 1'b1;
                    end else begin
                        r_blank <= r_blank + 4'd1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_a     <= '0;
                    r_e     <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign A    = r_a;
    assign E    = r_e;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: directed scenarios plus random traffic against a
// queue-based model that expands each latched scan into its per-cycle outputs.
module tb_scan_sel_gen;

    localparam int unsigned DWELL     = 4;
    localparam int unsigned BLANK_CYC = 1;

    typedef logic [4:0] obs_t;  // {A, E, busy, done}
    localparam obs_t IDLE_OBS = 5'b0;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       oneshot = 1'b0;
    logic [3:0] mask    = 4'b0;
    logic [1:0] A;
    logic       E;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int e_high = 0;
    int dones  = 0;

    obs_t       exp_q[$];
    logic [3:0] m_mask;
    logic       m_os;

    always #5 clk = ~clk;

    scan_sel_gen #(
        .DWELL     (DWELL)
`ifdef SCAN_SEL_BLANK_EN
        ,
        .BLANK_CYC (BLANK_CYC)
`endif
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .oneshot (oneshot),
        .mask    (mask),
        .A       (A),
        .E       (E),
        .busy    (busy),
        .done    (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    // One sweep: each enabled line for DWELL cycles, optional gaps, then done for one-shot.
    function automatic void push_sweep(input logic [3:0] m, input logic os);
        int last;
        last = -1;
        for (int i = 0; i < 4; i++) if (m[i]) last = i;
        for (int i = 0; i < 4; i++) begin
            if (!m[i]) continue;
            for (int n = 0; n < int'(DWELL); n++) exp_q.push_back({2'(i), 3'b110});
`ifdef SCAN_SEL_BLANK_EN
            if ((i != last) || !os)
                for (int n = 0; n < int'(BLANK_CYC); n++) exp_q.push_back({2'(i), 3'b010});
`endif
        end
        if (os) exp_q.push_back(5'b00001);
    endfunction

    function automatic obs_t model_step(input logic st, input logic sp, input logic os,
                                        input logic [3:0] m);
        if (exp_q.size() == 0) begin
            if (!(st && (m != 4'b0))) return IDLE_OBS;
            m_mask = m;
            m_os   = os;
            push_sweep(m, os);
        end else if (sp) begin
            exp_q.delete();
            return IDLE_OBS;
        end
        if (!m_os && (exp_q.size() < 2)) push_sweep(m_mask, 1'b0);
        return exp_q.pop_front();
    endfunction

    task automatic cycle(input logic st, input logic sp, input logic os, input logic [3:0] m,
                         input string tag);
        obs_t want;
        start   = st;
        stop    = sp;
        oneshot = os;
        mask    = m;
        @(posedge clk);
        want = model_step(st, sp, os, m);
        #1;
        check_eq(tag, {27'b0, A, E, busy, done}, {27'b0, want});
        if (E) e_high++;
        if (done) dones++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset", {27'b0, A, E, busy, done}, 32'd0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 4'b0, "idle");

        // Full one-shot sweep over all four lines
        e_high = 0; dones = 0;
        cycle(1'b1, 1'b0, 1'b1, 4'b1111, "t1_start");
        for (int i = 0; i < 22; i++) cycle(1'b0, 1'b0, 1'b0, 4'($urandom), "t1_run");
        check_eq("t1_e_cycles", e_high, 4 * DWELL);
        check_eq("t1_dones", dones, 1);

        // Sparse mask 1010
        e_high = 0; dones = 0;
        cycle(1'b1, 1'b0, 1'b1, 4'b1010, "t2_start");
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 1'b0, 4'b0, "t2_run");
        check_eq("t2_e_cycles", e_high, 2 * DWELL);
        check_eq("t2_dones", dones, 1);

        // Empty mask is ignored
        cycle(1'b1, 1'b0, 1'b1, 4'b0000, "t3_start");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 4'b0000, "t3_run");

        // Continuous single line, then stop
        e_high = 0; dones = 0;
        cycle(1'b1, 1'b0, 1'b0, 4'b0100, "t4_start");
        for (int i = 0; i < 39; i++) cycle(1'b0, 1'b0, 1'b1, 4'($urandom), "t4_run");
`ifndef SCAN_SEL_BLANK_EN
        check_eq("t4_e_cycles", e_high, 40);
`endif
        cycle(1'b0, 1'b1, 1'b0, 4'b0, "t4_stop");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 4'b0, "t4_after");
        check_eq("t4_dones", dones, 0);

        // Restart during a scan with a different mask
        cycle(1'b1, 1'b0, 1'b1, 4'b1111, "t5_start");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 4'b0, "t5_run");
        cycle(1'b1, 1'b0, 1'b0, 4'b0001, "t5_restart");
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 4'b0001, "t5_run2");

        // Asynchronous reset mid-dwell
        cycle(1'b1, 1'b0, 1'b1, 4'b0110, "t6_start");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 4'b0, "t6_run");
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async_rst", {27'b0, A, E, busy, done}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_eq("t6_held_rst", {27'b0, A, E, busy, done}, 32'd0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 4'b0, "t6_idle");
        cycle(1'b1, 1'b0, 1'b1, 4'b0110, "t6_restart");
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 1'b0, 4'b0, "t6_run2");

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
